// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one byte-wide RAM port between the instruction fetcher and the load/store buffer,
// serialising 1/2/4-byte accesses with round-robin grant, squash handling and I/O store back-pressure. rev 1.0
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rollback_flag_from_RoB,
  input  logic        io_buffer_full,
  input  logic        en_signal_from_fetcher,
  input  logic [31:0] pc_from_fetcher,
  input  logic        drop_flag_from_fetcher,
  output logic [31:0] inst_to_fetcher,
  output logic        ok_flag_to_fetcher,
  input  logic        en_signal_from_lsb,
  input  logic        rw_flag_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [2:0]  len_from_lsb,
  input  logic [31:0] data_from_lsb,
  output logic [31:0] data_to_lsb,
  output logic        ok_flag_to_lsb,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0]  state, state_nx;
  logic        f_pend, l_pend, l_rw, rr_lsb, wr_reg;
  logic [31:0] f_pc, l_addr, l_data;
  logic [2:0]  l_len, step, op_len;
  logic [31:0] op_data, rd_buf;

  logic        f_kill, f_req, l_req, l_go, grant_f, grant_l;
  logic        l_rw_eff;
  logic [31:0] f_addr_eff, l_addr_eff, l_data_eff;
  logic [2:0]  l_len_eff;
  logic        rd_done, st_done, abort;
  logic [4:0]  cap_sh;
  logic [31:0] rd_next;

  // A request pulse is visible to the arbiter in its own cycle so the first address goes out next cycle.
  always_comb begin
    f_kill     = drop_flag_from_fetcher | rollback_flag_from_RoB;
    f_addr_eff = en_signal_from_fetcher ? pc_from_fetcher : f_pc;
    l_rw_eff   = en_signal_from_lsb ? rw_flag_from_lsb : l_rw;
    l_addr_eff = en_signal_from_lsb ? addr_from_lsb : l_addr;
    l_len_eff  = en_signal_from_lsb ? len_from_lsb : l_len;
    l_data_eff = en_signal_from_lsb ? data_from_lsb : l_data;
    f_req      = (f_pend | en_signal_from_fetcher) & ~f_kill;
    l_req      = (l_pend | en_signal_from_lsb) & ~(rollback_flag_from_RoB & ~l_rw_eff);
    l_go       = l_req & ~(l_rw_eff & (l_addr_eff >= IO_BASE) & io_buffer_full);
    grant_l    = (state == S_IDLE) & l_go & (~f_req | rr_lsb);
    grant_f    = (state == S_IDLE) & f_req & (~l_go | ~rr_lsb);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else if (rdy_in) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (grant_l)      state_nx = l_rw_eff ? S_STORE : S_LOAD;
        else if (grant_f) state_nx = S_FETCH;
      end
      S_FETCH, S_LOAD: if (abort || rd_done) state_nx = S_IDLE;
      S_STORE:         if (st_done) state_nx = S_IDLE;
      default:         state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr  = wr_reg & rdy_in;
    abort   = ((state == S_FETCH) & f_kill) | ((state == S_LOAD) & rollback_flag_from_RoB);
    rd_done = ((state == S_FETCH) | (state == S_LOAD)) & (step == op_len);
    st_done = (state == S_STORE) & ((step + 3'd1) == op_len);
    // mem_din carries the byte addressed one step earlier.
    cap_sh  = {step[1:0] - 2'd1, 3'b000};
    rd_next = rd_buf | ({24'd0, mem_din} << cap_sh);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      f_pend <= 1'b0; l_pend <= 1'b0; l_rw <= 1'b0; rr_lsb <= 1'b1; wr_reg <= 1'b0;
      f_pc <= 32'd0; l_addr <= 32'd0; l_data <= 32'd0; l_len <= 3'd0;
      step <= 3'd0; op_len <= 3'd0; op_data <= 32'd0; rd_buf <= 32'd0;
      mem_a <= 32'd0; mem_dout <= 8'd0;
      inst_to_fetcher <= 32'd0; data_to_lsb <= 32'd0;
      ok_flag_to_fetcher <= 1'b0; ok_flag_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      ok_flag_to_fetcher <= 1'b0;
      ok_flag_to_lsb     <= 1'b0;
      f_pend <= f_req & ~grant_f;
      l_pend <= l_req & ~grant_l;
      if (en_signal_from_fetcher) f_pc <= pc_from_fetcher;
      if (en_signal_from_lsb) begin
        l_rw   <= rw_flag_from_lsb;
        l_addr <= addr_from_lsb;
        l_len  <= len_from_lsb;
        l_data <= data_from_lsb;
      end
      // Priority only flips when both sides actually competed.
      if (f_req && l_go && state == S_IDLE) rr_lsb <= grant_f;
      case (state)
        S_IDLE: begin
          if (grant_l) begin
            mem_a    <= l_addr_eff;
            op_len   <= l_len_eff;
            step     <= 3'd0;
            rd_buf   <= 32'd0;
            mem_dout <= l_data_eff[7:0];
            op_data  <= l_data_eff >> 8;
            wr_reg   <= l_rw_eff;
          end else if (grant_f) begin
            mem_a  <= f_addr_eff;
            op_len <= 3'd4;
            step   <= 3'd0;
            rd_buf <= 32'd0;
          end
        end
        S_FETCH, S_LOAD: begin
          if (!abort) begin
            if (step != 3'd0) rd_buf <= rd_next;
            if ((step + 3'd1) < op_len) mem_a <= mem_a + 32'd1;
            step <= step + 3'd1;
            if (rd_done) begin
              if (state == S_FETCH) begin
                inst_to_fetcher    <= rd_next;
                ok_flag_to_fetcher <= 1'b1;
              end else begin
                data_to_lsb    <= rd_next;
                ok_flag_to_lsb <= 1'b1;
              end
            end
          end
        end
        S_STORE: begin
          if (st_done) begin
            wr_reg         <= 1'b0;
            ok_flag_to_lsb <= 1'b1;
          end else begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= op_data[7:0];
            op_data  <= op_data >> 8;
            step     <= step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM port between the instruction fetcher (4-byte instruction reads) and the load/store buffer (1/2/4-byte loads and stores). Accepts one-cycle request pulses from each client, serialises each access into byte transfers, and returns assembled little-endian data with a one-cycle ok pulse. Handles squash: fetch drop, RoB rollback, and stalls I/O stores while the UART buffer is full.

## Interface
- `IO_BASE`, default 32'h30000: addresses at or above this value are I/O.
- `clk_in` input 1: clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: high = run; low = freeze all state.
- `rollback_flag_from_RoB` input 1: squash fetch and loads.
- `io_buffer_full` input 1: UART buffer full.
- `en_signal_from_fetcher` input 1: fetch request pulse.
- `pc_from_fetcher` input 32: fetch address.
- `drop_flag_from_fetcher` input 1: cancel the fetch.
- `inst_to_fetcher` output 32: fetched word.
- `ok_flag_to_fetcher` output 1: one-cycle done pulse.
- `en_signal_from_lsb` input 1: LSB request pulse.
- `rw_flag_from_lsb` input 1: 1 = store, 0 = load.
- `addr_from_lsb` input 32: byte address.
- `len_from_lsb` input 3: byte count, 1/2/4.
- `data_from_lsb` input 32: store data; low `len` bytes are used.
- `data_to_lsb` output 32: load data, zero-extended to 32 bits.
- `ok_flag_to_lsb` output 1: one-cycle done pulse.
- `mem_din` input 8: RAM read byte.
- `mem_dout` output 8: RAM write byte.
- `mem_a` output 32: RAM byte address.
- `mem_wr` output 1: 1 = write.

## Operation
- States:
  - IDLE: no access in progress.
  - FETCH: 4-byte read for the fetcher.
  - LOAD: N-byte read for the LSB.
  - STORE: N-byte write for the LSB.
- Pending registers:
  - `f_pend` (+pc) is set on `en_signal_from_fetcher`.
  - `l_pend` (+rw, addr, len, data) is set on `en_signal_from_lsb`.
  - A new pulse overwrites the stored fields.
  - `drop_flag_from_fetcher` or rollback clears `f_pend`; this wins over a same-cycle request.
  - Rollback clears `l_pend` only if that pending access is a load.
- Grant happens only in IDLE.
  - Only one side pending: grant it.
  - Both pending: round-robin, serving the side not served last. After reset the LSB is favoured.
  - An I/O store (addr ≥ `IO_BASE`) is not granted while `io_buffer_full` is high. The fetcher may take the port meanwhile.
- Reads: byte i address = base+i, for i = 0..N-1.
  - Byte i is placed at bits [8i+7:8i] of the result; upper bytes are 0.
- Stores: byte i = `data_from_lsb[8i+7:8i]` to base+i.
- Completion:
  - Result is registered to the data output.
  - The matching ok is high for exactly one cycle.
  - The pending bit is cleared and the FSM returns to IDLE.
- Abort: drop or rollback during FETCH, or rollback during LOAD.
  - Next state is IDLE, no ok, partial data discarded.
  - `mem_a` is not advanced further.
- STORE is never aborted; it always completes.
- `rdy_in` low: registers hold their values; `mem_wr` = write_reg & `rdy_in`, so no RAM write occurs while frozen.
- Reset:
  - State IDLE, both pending bits 0, RR pointer = LSB.
  - `mem_a`, `mem_dout`, `mem_wr` = 0.
  - Both oks = 0; `inst_to_fetcher`, `data_to_lsb` = 0.

## Timing
- RAM read latency is 1 cycle: the byte for the address driven in cycle c is valid on `mem_din` in cycle c+1.
- Cycle 0 = request pulse cycle, port IDLE, no competitor.
- Read of N bytes:
  - `mem_a` is driven in cycles 1..N.
  - Bytes are captured at the ends of cycles 2..N+1.
  - ok is high in cycle N+2; 4-byte fetch ok in cycle 6.
- Store of N bytes:
  - `mem_wr`=1 with `mem_a`/`mem_dout` in cycles 1..N.
  - ok is high in cycle N+1.
- The ok cycle is an IDLE cycle, so a pending request is granted in it. Back-to-back accesses therefore have no bubble beyond the ok cycle.
- `mem_wr` = 0 in every cycle not listed above.
- Abort asserted in cycle k: state is IDLE in cycle k+1.

## Test plan
- Fetch alone: RAM[0x100..0x103]=13,05,00,00, pulse fetch pc=0x100.
  - Cycle 6: `ok_flag_to_fetcher`=1 for one cycle, `inst_to_fetcher`=0x00000513.
  - `mem_a` sequence is 0x100..0x103.
- LSB store len=2, addr=0x200, data=0xDEADBEEF.
  - Cycles 1–2: `mem_wr`=1 writing EF then BE.
  - Cycle 3: ok.
  - RAM[0x202] is unchanged.
  - A following load len=4 @0x200 returns 0x????BEEF with the upper bytes as preloaded.
- Simultaneous fetch and LSB load pulses after reset.
  - LSB is served first; fetch follows.
  - Repeat simultaneous pulses: the fetcher is served first.
  - No ok is ever lost.
- Rollback in cycle 3 of a fetch: no fetch ok, FSM IDLE in cycle 4. A pending LSB store is still completed afterwards.
- `io_buffer_full`=1 with a store len=1 @0x30000:
  - `mem_wr` stays 0 while full.
  - A concurrent fetch completes.
  - Drop `io_buffer_full`: the store writes once and ok follows.
- Reset low mid-store: all outputs 0 immediately. After release the FSM is IDLE and the next fetch has normal 6-cycle latency.
